// File: rtl/key_sequence_encoder_pkg.sv
// Shared types and constants for the keyboard-to-UART escape sequence encoder.
package key_sequence_encoder_pkg;

   typedef logic [7:0] UartData_t;
   typedef UartData_t [3:0] SeqBuffer_t;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } EncState_t;

   localparam UartData_t ESC        = 8'h1B;
   localparam UartData_t CSI        = 8'h5B;
   localparam UartData_t SS3        = 8'h4F;
   localparam UartData_t FINAL_UP   = 8'h41;
   localparam UartData_t FINAL_DOWN = 8'h42;
   localparam UartData_t FINAL_RIGHT = 8'h43;
   localparam UartData_t FINAL_LEFT = 8'h44;
   localparam UartData_t FINAL_HOME = 8'h48;
   localparam UartData_t FINAL_END  = 8'h46;
   localparam UartData_t DEL_PARAM  = 8'h33;
   localparam UartData_t TILDE      = 8'h7E;

   // PS/2 set-2 make codes that arrive with the E0 prefix
   localparam logic [7:0] SC_UP     = 8'h75;
   localparam logic [7:0] SC_DOWN   = 8'h72;
   localparam logic [7:0] SC_RIGHT  = 8'h74;
   localparam logic [7:0] SC_LEFT   = 8'h6B;
   localparam logic [7:0] SC_HOME   = 8'h6C;
   localparam logic [7:0] SC_END    = 8'h69;
   localparam logic [7:0] SC_DELETE = 8'h71;

   // Byte 0 of the buffer is emitted first.
   function automatic SeqBuffer_t cursor_seq(input UartData_t intro, input UartData_t fin);
      return {8'h00, fin, intro, ESC};
   endfunction

endpackage

// File: rtl/key_sequence_lookup.sv
// Combinational classification of a decoded key into an emit buffer and length.
module key_sequence_lookup
   import key_sequence_encoder_pkg::*;
(
   input  logic [7:0] scanCode,
   input  logic       extended,
   input  logic [7:0] asciiCode,
   input  logic       app_cursor_mode,
   output SeqBuffer_t buffer,
   output logic [2:0] length,
   output logic       valid
);

   UartData_t intro;

   always_comb begin
      intro  = app_cursor_mode ? SS3 : CSI;
      buffer = '0;
      length = 3'd0;
      valid  = 1'b0;
      if (extended) begin
         valid  = 1'b1;
         length = 3'd3;
         case (scanCode)
            SC_UP:     buffer = cursor_seq(intro, FINAL_UP);
            SC_DOWN:   buffer = cursor_seq(intro, FINAL_DOWN);
            SC_RIGHT:  buffer = cursor_seq(intro, FINAL_RIGHT);
            SC_LEFT:   buffer = cursor_seq(intro, FINAL_LEFT);
            SC_HOME:   buffer = cursor_seq(intro, FINAL_HOME);
            SC_END:    buffer = cursor_seq(intro, FINAL_END);
            SC_DELETE: begin
               // Delete always uses the CSI form, independent of cursor mode
               buffer = {TILDE, DEL_PARAM, CSI, ESC};
               length = 3'd4;
            end
            default: begin
               valid  = 1'b0;
               length = 3'd0;
            end
         endcase
      end else if (asciiCode != 8'h00) begin
         buffer = {8'h00, 8'h00, 8'h00, asciiCode};
         length = 3'd1;
         valid  = 1'b1;
      end
   end

endmodule

// File: rtl/key_sequence_encoder.sv
// Turns decoded key events into ASCII or ANSI escape byte sequences on a UART TX FIFO.
module key_sequence_encoder
   import key_sequence_encoder_pkg::*;
#(
   parameter bit AppCursorMode = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       keyValid,
   input  logic [7:0] scanCode,
   input  logic       extended,
   input  logic [7:0] asciiCode,
   input  logic       fifoFull,
   output logic       fifoWriteRequest,
   output UartData_t  fifoInData,
   output logic       busy,
   output logic       dropped
);

   EncState_t  state, state_next;
   SeqBuffer_t buffer, lk_buffer;
   logic [2:0] length, lk_length;
   logic [1:0] index;
   logic       lk_valid;
   logic       accept;
   logic       last_write;

   key_sequence_lookup u_lookup (
      .scanCode        (scanCode),
      .extended        (extended),
      .asciiCode       (asciiCode),
      .app_cursor_mode (AppCursorMode),
      .buffer          (lk_buffer),
      .length          (lk_length),
      .valid           (lk_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept)     state_next = EMIT;
         EMIT: if (last_write) state_next = IDLE;
         default:              state_next = IDLE;
      endcase
   end

   always_comb begin
      busy             = (state == EMIT);
      fifoWriteRequest = (state == EMIT) && !fifoFull;
      fifoInData       = buffer[index];
      accept           = (state == IDLE) && keyValid && lk_valid;
      last_write       = fifoWriteRequest && ({1'b0, index} == (length - 3'd1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buffer  <= '0;
         length  <= 3'd0;
         index   <= 2'd0;
         dropped <= 1'b0;
      end else begin
         // Any key arriving while a sequence is still pending is discarded
         dropped <= keyValid && (state == EMIT);
         if (accept) begin
            buffer <= lk_buffer;
            length <= lk_length;
            index  <= 2'd0;
         end else if (last_write) begin
            index <= 2'd0;
         end else if (fifoWriteRequest) begin
            index <= index + 2'd1;
         end
      end
   end

endmodule

// File: doc/key_sequence_encoder.md
KEY_SEQUENCE_ENCODER -- requirements
Module: key_sequence_encoder

Interface
REQ-001 Parameter AppCursorMode, default 0: 0 = cursor keys emit CSI form (1B 5B x); 1 = SS3 form (1B 4F x).
REQ-002 clk  input  1  system clock; single clock domain; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 keyValid  input  1  one-cycle pulse, a decoded make-code is presented.
REQ-005 scanCode  input  8  PS/2 set-2 make code, valid with keyValid.
REQ-006 extended  input  1  code carried E0 prefix, valid with keyValid.
REQ-007 asciiCode  input  8  translated ASCII, 00 = no printable mapping, valid with keyValid.
REQ-008 fifoFull  input  1  UART TX FIFO full.
REQ-009 fifoWriteRequest  output  1  FIFO write strobe.
REQ-010 fifoInData  output  8  byte written when fifoWriteRequest=1.
REQ-011 busy  output  1  high while a sequence is pending emission.
REQ-012 dropped  output  1  one-cycle pulse, a key was discarded.

Function
REQ-013 States IDLE and EMIT only; IDLE->EMIT on accepted key; EMIT->IDLE in the cycle the last byte is written.
REQ-014 In IDLE, keyValid classifies the key in that cycle and loads a 4-byte sequence buffer, a length (1..4) and index 0.
REQ-015 Extended map: 75->Up 'A', 72->Down 'B', 74->Right 'C', 6B->Left 'D', 6C->Home 'H', 69->End 'F' as 1B, 5B|4F, final; 71->Delete as 1B 5B 33 7E regardless of AppCursorMode.
REQ-016 Home/End follow AppCursorMode like cursor keys.
REQ-017 Non-extended key with asciiCode != 00 yields single byte asciiCode.
REQ-018 Extended key outside the map, or non-extended with asciiCode = 00: no load, stay IDLE, no dropped pulse.
REQ-019 fifoWriteRequest = (state==EMIT) && !fifoFull, combinational from current state and fifoFull; never asserted while fifoFull=1.
REQ-020 fifoInData = buffer[index], driven from registers; holds value while stalled.
REQ-021 Index increments by 1 on each write; writes occur on consecutive cycles while fifoFull=0.
REQ-022 Latency: keyValid in cycle N -> first write in cycle N+1 if fifoFull=0 then.
REQ-023 fifoFull asserted in EMIT: no write, index and buffer frozen, resume next non-full cycle; no timeout.
REQ-024 keyValid while in EMIT (including the final-write cycle): key discarded, dropped pulses next cycle, current sequence unaffected.
REQ-025 busy = (state==EMIT).
REQ-026 No key is accepted in the same cycle the last byte is written; it is dropped per REQ-024.

Reset
REQ-027 rst forces state IDLE, index 0, length 0, buffer 00, dropped 0 at next edge; fifoWriteRequest, busy 0 from that edge.
REQ-028 rst mid-sequence abandons remaining bytes; no partial-sequence completion after release.
REQ-029 rst has priority over keyValid in the same cycle.

Structure
REQ-030 Escape constants (ESC 1B, CSI 5B, SS3 4F, finals, 33, 7E) and set-2 extended scan-code constants reside in the shared DataType package alongside UartData_t; fifoInData typed UartData_t.
REQ-031 Classification is one sub-module, key_sequence_lookup (combinational: scanCode, extended, asciiCode, AppCursorMode -> 4-byte buffer, length, valid); the FSM stays in key_sequence_encoder.
REQ-032 Instantiated in the keyboard controller between the scan-code translator and the UART TX FIFO write port.

Verification
REQ-033 asciiCode 61, extended 0, fifoFull 0 -> single write 61 in cycle N+1, busy 1 for one cycle.
REQ-034 extended 1, scanCode 75, AppCursorMode 0 -> writes 1B, 5B, 41 in N+1..N+3; AppCursorMode 1 -> 1B, 4F, 41.
REQ-035 extended 1, scanCode 71 -> 1B, 5B, 33, 7E consecutive; fifoFull high two cycles after 5B -> 33 held, no strobe, resumes 33, 7E.
REQ-036 Second keyValid (asciiCode 62) during Up sequence -> dropped pulse one cycle later, Up bytes unchanged, 62 never written.
REQ-037 rst after second byte of Delete -> no further writes, busy 0, next key 61 emits 61 only.
REQ-038 extended 1, scanCode 12 -> no write, busy 0, dropped 0.
